// File: rtl/atm_ui_pkg.sv
// Shared definitions for the ATM user-input path: entry FSM encoding,
// BCD limits and button index constants used by digit_entry.
package atm_ui_pkg;

  localparam int DEFAULT_DIGITS = 4;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam int BTN_C = 0;
  localparam int BTN_L = 1;
  localparam int BTN_R = 2;
  localparam int NUM_BTNS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    DONE  = 2'd2
  } entry_state_e;

  // A switch value is a usable decimal digit only in the range 0..9.
  function automatic logic bcd_valid(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises a raw push-button and accepts a new level only after it has
// been stable for DEBOUNCE_CYCLES consecutive samples. Emits a one-cycle
// press pulse on each accepted 0->1 transition.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser, then a stability counter that restarts whenever
  // the synchronised sample agrees with the accepted level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_p1;
        cnt   <= '0;
        press <= sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/digit_entry.sv
// Collects a fixed-length BCD number (account number or PIN) from the
// switches and three debounced buttons: commit digit, backspace, enter.
module digit_entry
  import atm_ui_pkg::*;
#(
  parameter  int DEBOUNCE_CYCLES = 1000000,
  parameter  int DIGITS          = DEFAULT_DIGITS,
  localparam int VALUE_W         = 4 * DIGITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [3:0]         sw,
  input  logic               BTNC,
  input  logic               BTNL,
  input  logic               BTNR,
  output logic [VALUE_W-1:0] value,
  output logic [2:0]         digit_count,
  output logic               done,
  output logic               entry_error
);

  localparam logic [2:0] FULL_COUNT = 3'(DIGITS);

  logic [NUM_BTNS-1:0] raw_btn;
  logic [NUM_BTNS-1:0] btn_level;
  logic [NUM_BTNS-1:0] btn_press;
  logic [NUM_BTNS-1:0] btn_hit;

  entry_state_e state;

  logic act_backspace;
  logic act_enter;
  logic act_commit;

  assign raw_btn[BTN_C] = BTNC;
  assign raw_btn[BTN_L] = BTNL;
  assign raw_btn[BTN_R] = BTNR;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_btn[i]),
      .level(btn_level[i]),
      .press(btn_press[i])
    );
  end

  // A press pulse always coincides with a high accepted level.
  assign btn_hit = btn_press & btn_level;

  // One action per cycle: backspace beats enter beats commit; losers are dropped.
  always_comb begin
    act_backspace = btn_hit[BTN_L];
    act_enter     = btn_hit[BTN_R] & ~btn_hit[BTN_L];
    act_commit    = btn_hit[BTN_C] & ~btn_hit[BTN_L] & ~btn_hit[BTN_R];
  end

  // Entry FSM with registered value, count and single-cycle status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      value       <= '0;
      digit_count <= '0;
      done        <= 1'b0;
      entry_error <= 1'b0;
    end else begin
      done        <= 1'b0;
      entry_error <= 1'b0;
      if (!enable) begin
        state       <= IDLE;
        value       <= '0;
        digit_count <= '0;
      end else begin
        case (state)
          IDLE: begin
            value       <= '0;
            digit_count <= '0;
            state       <= ENTRY;
          end
          ENTRY: begin
            if (act_backspace) begin
              if (digit_count != 3'd0) begin
                value       <= value >> 4;
                digit_count <= digit_count - 3'd1;
              end
            end else if (act_enter) begin
              if (digit_count == FULL_COUNT) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                entry_error <= 1'b1;
              end
            end else if (act_commit) begin
              if (!bcd_valid(sw) || digit_count == FULL_COUNT) begin
                entry_error <= 1'b1;
              end else begin
                value       <= (value << 4) | VALUE_W'(sw);
                digit_count <= digit_count + 3'd1;
              end
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
